// File: rtl/uart_multi_tap.sv
// uart_multi_tap: bridges a UART RX/TX byte stream to NUM_CH independent
// ready/valid register channels. Command bytes select an operation and a
// channel; payload bytes travel LSB first. Writes are acknowledged, reads are
// returned as a header plus payload, and bad commands or stalled targets
// produce an error response.
module uart_multi_tap #(
  parameter int                  NUM_CH     = 4,
  parameter int                  DATA_WIDTH = 64,
  parameter logic [4*NUM_CH-1:0] CH_BYTES   = {NUM_CH{4'd8}},
  parameter int                  TIMEOUT    = 1024
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  output logic                         READ_O,
  input  logic [7:0]                   DATA_REC_I,
  input  logic                         RX_EMPTY_I,
  input  logic                         CMD_REC_I,
  input  logic                         TX_READY_I,
  output logic                         WRITE_O,
  output logic [7:0]                   DATA_SEND_O,
  output logic                         SEND_COMMAND_O,
  output logic [7:0]                   COMMAND_O,
  output logic [NUM_CH-1:0]            WR_VALID_O,
  output logic [DATA_WIDTH-1:0]        WR_DATA_O,
  input  logic [NUM_CH-1:0]            WR_READY_I,
  input  logic [NUM_CH-1:0]            RD_VALID_I,
  input  logic [NUM_CH*DATA_WIDTH-1:0] RD_DATA_I,
  output logic [NUM_CH-1:0]            RD_READY_O,
  output logic                         BUSY_O
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_CONT  = 3'b011;
  localparam logic [2:0] OP_RESET = 3'b100;
  localparam logic [2:0] RSP_HDR  = 3'b001;
  localparam logic [2:0] RSP_ACK  = 3'b101;
  localparam logic [2:0] RSP_ERR  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_DATA, S_WR_REQ, S_RD_REQ, S_TX_HDR, S_TX_DATA, S_TX_RESP
  } state_t;

  typedef enum logic [1:0] {M_NOP, M_READ, M_CONT} mode_t;

  state_t                state, state_n;
  mode_t                 mode, mode_n;
  logic [4:0]            ch, ch_n;
  logic [7:0]            resp, resp_n;
  logic                  rx_vld, rx_cmd;
  logic [7:0]            rx_byte;
  logic [3:0]            cnt;
  logic [TW-1:0]         tmo;
  logic [DATA_WIDTH-1:0] wr_data, rd_shift;
  logic                  wr_clr, rx_data_byte, tmo_hit, last_byte, cmd_pending;
  logic [CW-1:0]         ch_idx;
  logic [NUM_CH-1:0]     ch_onehot;
  logic [3:0]            ch_len;

  // Payload length in bytes of the given channel.
  function automatic logic [3:0] chan_len(input logic [CW-1:0] idx);
    return CH_BYTES[idx*4 +: 4];
  endfunction

  assign ch_idx       = ch[CW-1:0];
  assign ch_onehot    = NUM_CH'(1) << ch_idx;
  assign ch_len       = chan_len(ch_idx);
  assign last_byte    = (cnt == ch_len - 4'd1);
  assign rx_data_byte = (state == S_RX_DATA) && rx_vld && !rx_cmd;
  assign tmo_hit      = (TIMEOUT != 0) && (tmo == TW'(TIMEOUT - 1));
  assign cmd_pending  = !RX_EMPTY_I && CMD_REC_I;

  // FSM state register together with the per-transaction context.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state <= S_IDLE;
      mode  <= M_NOP;
      ch    <= '0;
      resp  <= '0;
    end else begin
      state <= state_n;
      mode  <= mode_n;
      ch    <= ch_n;
      resp  <= resp_n;
    end
  end

  // Next-state decode and all handshake outputs.
  always_comb begin
    state_n        = state;
    mode_n         = mode;
    ch_n           = ch;
    resp_n         = resp;
    wr_clr         = 1'b0;
    READ_O         = 1'b0;
    WRITE_O        = 1'b0;
    DATA_SEND_O    = '0;
    SEND_COMMAND_O = 1'b0;
    COMMAND_O      = '0;
    WR_VALID_O     = '0;
    RD_READY_O     = '0;
    BUSY_O         = (state != S_IDLE);
    WR_DATA_O      = wr_data;

    case (state)
      S_IDLE, S_RX_DATA: begin
        // One byte in flight at a time: a popped byte is decoded before the next pop.
        READ_O = !RX_EMPTY_I && !rx_vld;
        if (rx_vld && rx_cmd) begin
          // Any command, including one arriving mid-write, drops a partial payload.
          state_n = S_IDLE;
          if (rx_byte[7:5] > OP_RESET || int'(rx_byte[4:0]) >= NUM_CH) begin
            state_n = S_TX_RESP;
            resp_n  = {RSP_ERR, rx_byte[4:0]};
            mode_n  = M_NOP;
          end else begin
            case (rx_byte[7:5])
              OP_READ: begin
                ch_n    = rx_byte[4:0];
                state_n = S_RD_REQ;
                mode_n  = M_READ;
              end
              OP_WRITE: begin
                ch_n    = rx_byte[4:0];
                state_n = S_RX_DATA;
                wr_clr  = 1'b1;
              end
              OP_CONT: begin
                ch_n    = rx_byte[4:0];
                state_n = S_RD_REQ;
                mode_n  = M_CONT;
              end
              OP_RESET: mode_n = M_NOP;
              default: ;
            endcase
          end
        end else if (rx_data_byte && last_byte) begin
          state_n = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        WR_VALID_O = ch_onehot;
        if (WR_READY_I[ch_idx]) begin
          state_n = S_TX_RESP;
          resp_n  = {RSP_ACK, ch};
        end else if (tmo_hit) begin
          state_n = S_TX_RESP;
          resp_n  = {RSP_ERR, ch};
          mode_n  = M_NOP;
        end
      end
      S_RD_REQ: begin
        RD_READY_O = ch_onehot;
        if (RD_VALID_I[ch_idx]) begin
          state_n = S_TX_HDR;
        end else if (tmo_hit) begin
          state_n = S_TX_RESP;
          resp_n  = {RSP_ERR, ch};
          mode_n  = M_NOP;
        end
      end
      S_TX_HDR: begin
        COMMAND_O      = {RSP_HDR, ch};
        SEND_COMMAND_O = TX_READY_I;
        if (TX_READY_I) state_n = S_TX_DATA;
      end
      S_TX_DATA: begin
        DATA_SEND_O = rd_shift[7:0];
        WRITE_O     = TX_READY_I;
        if (TX_READY_I && last_byte) begin
          // A continuous read yields to a queued command between frames.
          state_n = (mode == M_CONT && !cmd_pending) ? S_RD_REQ : S_IDLE;
        end
      end
      S_TX_RESP: begin
        COMMAND_O      = resp;
        SEND_COMMAND_O = TX_READY_I;
        if (TX_READY_I) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // RX capture, byte counter, timeout counter and payload shift registers.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      rx_vld   <= 1'b0;
      rx_cmd   <= 1'b0;
      rx_byte  <= '0;
      cnt      <= '0;
      tmo      <= '0;
      wr_data  <= '0;
      rd_shift <= '0;
    end else begin
      rx_vld <= READ_O;
      if (READ_O) begin
        rx_byte <= DATA_REC_I;
        rx_cmd  <= CMD_REC_I;
      end

      if (state_n != state || wr_clr) cnt <= '0;
      else if (rx_data_byte || WRITE_O) cnt <= cnt + 4'd1;

      if (state_n != state) tmo <= '0;
      else if (state == S_WR_REQ || state == S_RD_REQ) tmo <= tmo + TW'(1);

      // Clearing on each WRITE keeps bytes beyond the channel length at zero.
      if (wr_clr) wr_data <= '0;
      else if (rx_data_byte) wr_data[cnt*8 +: 8] <= rx_byte;

      if (state == S_RD_REQ && RD_VALID_I[ch_idx])
        rd_shift <= RD_DATA_I[ch_idx*DATA_WIDTH +: DATA_WIDTH];
      else if (WRITE_O)
        rd_shift <= rd_shift >> 8;
    end
  end

endmodule
